control_unit: RTL and testbench

Four-state (Fetch/Decode/Execute/Writeback) control unit with a small 8-bit datapath for the board-level toy CPU. It takes one 8-bit instruction per pass from the slide switches, executes it against two internal registers R1/R2, and reports state and instruction on the LEDs. The low nibble of each register is shown on two seven-segment displays. It is the top of the CPU; only `display_hex` sits below it.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/display_hex.sv | 31 +++
 rtl/control_unit.sv | 108 ++++++++++
 tb/tb_control_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the toy CPU: FSM states, ALU opcodes, register select
// and the ALU itself.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_INC = 3'b011,
        OP_DEC = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } opcode_t;

    localparam logic [1:0] REG_R1 = 2'b00;

    // Any select other than REG_R1 addresses R2.
    function automatic logic [7:0] sel_reg(input logic [1:0] sel,
                                           input logic [7:0] r1,
                                           input logic [7:0] r2);
        return (sel == REG_R1) ? r1 : r2;
    endfunction

    function automatic logic [7:0] alu(input opcode_t op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        case (op)
            OP_NOP: r = a;
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_INC: r = a + 8'd1;
            OP_DEC: r = a - 8'd1;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/display_hex.sv
// Hex digit to active-low seven-segment pattern (bit 0 = segment a).
module display_hex (
    input  logic [31:0] value,
    output logic [6:0]  hex
);
    logic unused_hi;
    assign unused_hi = ^value[31:4];

    always_comb begin
        hex = 7'h7F;
        case (value[3:0])
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Fetch/Decode/Execute/Writeback control unit with R1/R2 datapath.
// Optional CU_IMMEDIATE_MODE_EN: mode bit selects the regB field as an immediate.
module control_unit
    import cpu_pkg::*;
(
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);
    logic clk;
    logic rst;
    assign clk = KEY[0];
    assign rst = KEY[1];

    logic unused_sw;
    assign unused_sw = ^SW[9:8];

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [7:0] res_q, res_d;
    logic [7:0] r1_q, r1_d;
    logic [7:0] r2_q, r2_d;

    opcode_t    opcode;
    logic [1:0] reg_a;
    logic [1:0] reg_b;
    assign opcode = opcode_t'(ir_q[6:4]);
    assign reg_a  = ir_q[3:2];
    assign reg_b  = ir_q[1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_d  = ir_q;
        opa_d = opa_q;
        opb_d = opb_q;
        res_d = res_q;
        r1_d  = r1_q;
        r2_d  = r2_q;
        case (state_q)
            S_FETCH: ir_d = SW[7:0];
            S_DECODE: begin
                opa_d = sel_reg(reg_a, r1_q, r2_q);
                opb_d = sel_reg(reg_b, r1_q, r2_q);
`ifdef CU_IMMEDIATE_MODE_EN
                if (ir_q[7]) opb_d = {6'b0, reg_b};
`endif
            end
            S_EXEC: res_d = alu(opcode, opa_q, opb_q);
            S_WB: begin
                if (opcode != OP_NOP) begin
                    if (reg_a == REG_R1) r1_d = res_q;
                    else                 r2_d = res_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath runs on the falling edge so each state's work lands mid-cycle.
    always_ff @(negedge clk) begin
        if (rst) begin
            ir_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            r1_q  <= '0;
            r2_q  <= '0;
        end else begin
            ir_q  <= ir_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
        end
    end

    assign LEDR = {ir_q, state_q};

    display_hex u_hex0 (
        .value ({24'b0, r1_q}),
        .hex   (HEX0)
    );

    display_hex u_hex1 (
        .value ({24'b0, r2_q}),
        .hex   (HEX1)
    );
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expectations,
// a monitor checks them after every falling edge.
module tb_control_unit;
    logic       clk;
    logic       rst;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    control_unit dut (
        .KEY  ({rst, clk}),
        .SW   (SW),
        .LEDR (LEDR),
        .HEX0 (HEX0),
        .HEX1 (HEX1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] ir;
        logic [7:0] r1;
        logic [7:0] r2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] cur_r1 = 8'h00;
    logic [7:0] cur_r2 = 8'h00;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("LEDR", 32'(LEDR), 32'({e.ir, e.st}));
                check("R1",   32'(dut.r1_q), 32'(e.r1));
                check("R2",   32'(dut.r2_q), 32'(e.r2));
                check("HEX0", 32'(HEX0), 32'(seg_tab[e.r1[3:0]]));
                check("HEX1", 32'(HEX1), 32'(seg_tab[e.r2[3:0]]));
            end
        end
    end

    // Entered at posedge+1 in F; returns at posedge+1 in the next F.
    task automatic run(input logic [7:0] instr, input logic [7:0] n1, input logic [7:0] n2);
        SW = {2'b10, instr};
        sb.push_back(exp_t'{2'b00, instr, cur_r1, cur_r2});
        sb.push_back(exp_t'{2'b01, instr, cur_r1, cur_r2});
        sb.push_back(exp_t'{2'b10, instr, cur_r1, cur_r2});
        sb.push_back(exp_t'{2'b11, instr, n1, n2});
        @(posedge clk);
        #2;
        SW = ~SW;
        repeat (3) @(posedge clk);
        #1;
        cur_r1 = n1;
        cur_r2 = n2;
    endtask

    initial begin : stim
        rst = 1'b1;
        SW  = '0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(exp_t'{2'b00, 8'h00, 8'h00, 8'h00});
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(8'h30, 8'h01, 8'h00);   // INC R1
        run(8'h30, 8'h02, 8'h00);   // INC R1
        run(8'h10, 8'h04, 8'h00);   // ADD R1,R1
        run(8'h34, 8'h04, 8'h01);   // INC R2
        run(8'h24, 8'h04, 8'hFD);   // SUB R2,R1: 1-4 wraps
        run(8'h70, 8'h00, 8'hFD);   // XOR R1,R1
        run(8'h40, 8'hFF, 8'hFD);   // DEC R1 from 0
        run(8'h30, 8'h00, 8'hFD);   // INC R1 from FF
        run(8'h61, 8'hFD, 8'hFD);   // OR R1,R2
        run(8'h4C, 8'hFD, 8'hFC);   // DEC R2 via select 11
        run(8'h51, 8'hFC, 8'hFC);   // AND R1,R2
        run(8'h0D, 8'hFC, 8'hFC);   // NOP: no writeback
        run(8'h25, 8'hFC, 8'h00);   // SUB R2,R2
        run(8'h30, 8'hFD, 8'h00);   // INC R1
        run(8'h10, 8'hFA, 8'h00);   // ADD R1,R1

        // Reset during E of ADD R1,R1: abandoned, everything cleared.
        SW = {2'b00, 8'h10};
        sb.push_back(exp_t'{2'b00, 8'h10, cur_r1, cur_r2});
        sb.push_back(exp_t'{2'b01, 8'h10, cur_r1, cur_r2});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back(exp_t'{2'b10, 8'h00, 8'h00, 8'h00});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_r1 = 8'h00;
        cur_r2 = 8'h00;

        run(8'h34, 8'h00, 8'h01);   // INC R2
`ifdef CU_IMMEDIATE_MODE_EN
        run(8'h93, 8'h03, 8'h01);   // ADD R1,#3
`else
        run(8'h93, 8'h01, 8'h01);   // mode ignored: ADD R1,R2
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
